// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard control over a shadow EX/MEM/WB scoreboard.
// Define HAZARD_FWD_EN to enable forwarding selects; otherwise every producer match stalls.
module id_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_idValid,
   input  logic [4:0]       i_rs1,
   input  logic [4:0]       i_rs2,
   input  logic             i_useRs1,
   input  logic             i_useRs2,
   input  logic [4:0]       i_rd,
   input  logic             i_regWrite,
   input  logic             i_memRead,
   input  logic             i_branchTaken,
   output logic             o_stallIF,
   output logic             o_stallID,
   output logic             o_bubbleEX,
   output logic             o_flushID,
   output logic [1:0]       o_fwdA,
   output logic [1:0]       o_fwdB,
   output logic [CNT_W-1:0] o_stallCnt
);
   logic       r_ex_v, r_ex_rw, r_ex_mr, r_mem_v, r_mem_rw, r_wb_v, r_wb_rw;
   logic [4:0] r_ex_rd, r_mem_rd, r_wb_rd;
   logic       w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
   logic       w_hazard, w_stall, w_adv;

   function automatic logic f_match(input logic v, input logic rw, input logic [4:0] rd,
                                    input logic [4:0] r, input logic use_r);
      return v & rw & (rd == r) & (r != 5'd0) & use_r;
   endfunction

   always_comb begin
      w_ex_a  = f_match(r_ex_v,  r_ex_rw,  r_ex_rd,  i_rs1, i_useRs1);
      w_ex_b  = f_match(r_ex_v,  r_ex_rw,  r_ex_rd,  i_rs2, i_useRs2);
      w_mem_a = f_match(r_mem_v, r_mem_rw, r_mem_rd, i_rs1, i_useRs1);
      w_mem_b = f_match(r_mem_v, r_mem_rw, r_mem_rd, i_rs2, i_useRs2);
      w_wb_a  = f_match(r_wb_v,  r_wb_rw,  r_wb_rd,  i_rs1, i_useRs1);
      w_wb_b  = f_match(r_wb_v,  r_wb_rw,  r_wb_rd,  i_rs2, i_useRs2);
`ifdef HAZARD_FWD_EN
      w_hazard = (r_ex_mr & (w_ex_a | w_ex_b)) | w_wb_a | w_wb_b;
`else
      w_hazard = w_ex_a | w_ex_b | w_mem_a | w_mem_b | w_wb_a | w_wb_b;
`endif
      w_stall    = ~i_reset & i_idValid & w_hazard;
      o_flushID  = ~i_reset & i_branchTaken;
      o_stallIF  = w_stall & ~i_branchTaken;
      o_stallID  = o_stallIF;
      o_bubbleEX = w_stall | o_flushID;
      w_adv      = i_idValid & ~o_bubbleEX;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         {r_ex_v, r_mem_v, r_wb_v} <= '0;
         {r_ex_rw, r_ex_mr, r_mem_rw, r_wb_rw} <= '0;
         {r_ex_rd, r_mem_rd, r_wb_rd} <= '0;
         o_stallCnt <= '0;
      end else begin
         {r_wb_v, r_wb_rw, r_wb_rd}    <= {r_mem_v, r_mem_rw, r_mem_rd};
         {r_mem_v, r_mem_rw, r_mem_rd} <= {r_ex_v, r_ex_rw, r_ex_rd};
         r_ex_v  <= w_adv;
         r_ex_rw <= i_regWrite;
         r_ex_mr <= i_memRead;
         r_ex_rd <= i_rd;
         if (o_stallID && o_stallCnt != '1) o_stallCnt <= o_stallCnt + 1'b1;
      end
   end

`ifdef HAZARD_FWD_EN
   // EX producer is the youngest, so it takes priority over MEM
   always_ff @(posedge i_clk) begin
      if (i_reset || !w_adv) begin
         o_fwdA <= 2'b00;
         o_fwdB <= 2'b00;
      end else begin
         o_fwdA <= w_ex_a ? 2'b01 : w_mem_a ? 2'b10 : 2'b00;
         o_fwdB <= w_ex_b ? 2'b01 : w_mem_b ? 2'b10 : 2'b00;
      end
   end
`else
   assign o_fwdA = 2'b00;
   assign o_fwdB = 2'b00;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: randomized check of id_hazard_ctrl against an in-flight instruction model.
module tb_id_hazard_ctrl;
   localparam int CW = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, idValid, useRs1, useRs2, regWrite, memRead, branchTaken;
   logic [4:0] rs1, rs2, rd;
   logic stallIF, stallID, bubbleEX, flushID;
   logic [1:0] fwdA, fwdB;
   logic [CW-1:0] stallCnt;
   int n_chk = 0, n_fail = 0;

   // in-flight instructions indexed by age: 1 = EX, 2 = MEM, 3 = WB
   logic       mv[1:3], mrw[1:3], mmr[1:3];
   logic [4:0] mrd[1:3];
   logic [1:0] mfa, mfb;
   int         mcnt;

   id_hazard_ctrl #(.CNT_W(CW)) dut (
      .i_clk(clk), .i_reset(reset), .i_idValid(idValid), .i_rs1(rs1), .i_rs2(rs2),
      .i_useRs1(useRs1), .i_useRs2(useRs2), .i_rd(rd), .i_regWrite(regWrite),
      .i_memRead(memRead), .i_branchTaken(branchTaken), .o_stallIF(stallIF),
      .o_stallID(stallID), .o_bubbleEX(bubbleEX), .o_flushID(flushID),
      .o_fwdA(fwdA), .o_fwdB(fwdB), .o_stallCnt(stallCnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:1] producers(input logic [4:0] r, input logic u);
      logic [3:1] m;
      for (int d = 1; d <= 3; d++) m[d] = mv[d] && mrw[d] && mrd[d] == r && r != 0 && u;
      return m;
   endfunction

   function automatic logic needs_stall(input logic [3:1] m);
`ifdef HAZARD_FWD_EN
      return (m[1] && mmr[1]) || m[3];
`else
      return |m;
`endif
   endfunction

   function automatic logic [1:0] fwd_src(input logic [3:1] m);
`ifdef HAZARD_FWD_EN
      return m[1] ? 2'b01 : m[2] ? 2'b10 : 2'b00;
`else
      return 2'b00;
`endif
   endfunction

   task automatic model_clear();
      for (int d = 1; d <= 3; d++) begin
         mv[d] = 0; mrw[d] = 0; mmr[d] = 0; mrd[d] = 0;
      end
      mfa = 0; mfb = 0; mcnt = 0;
   endtask

   initial begin
      logic [3:1] ma, mb;
      logic st, fl, e_stall, e_bub, adv;
      {idValid, useRs1, useRs2, regWrite, memRead, branchTaken} = '0;
      {rs1, rs2, rd} = '0;
      reset = 1;
      repeat (2) @(negedge clk);
      model_clear();
      #1;
      chk("reset_stallIF", stallIF, 0);
      chk("reset_bubbleEX", bubbleEX, 0);
      chk("reset_flushID", flushID, 0);
      chk("reset_fwdA", fwdA, 0);
      chk("reset_fwdB", fwdB, 0);
      chk("reset_cnt", stallCnt, 0);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         reset       = ($urandom_range(99) < 3);
         idValid     = ($urandom_range(99) < 85);
         rs1         = 5'($urandom_range(3));
         rs2         = 5'($urandom_range(3));
         rd          = 5'($urandom_range(3));
         useRs1      = ($urandom_range(99) < 80);
         useRs2      = ($urandom_range(99) < 80);
         regWrite    = ($urandom_range(99) < 70);
         memRead     = ($urandom_range(99) < 30);
         branchTaken = ($urandom_range(99) < 8);
         #1;
         ma = producers(rs1, useRs1);
         mb = producers(rs2, useRs2);
         st = !reset && idValid && (needs_stall(ma) || needs_stall(mb));
         fl = !reset && branchTaken;
         e_stall = st && !branchTaken;
         e_bub = st || fl;
         adv = idValid && !e_bub;
         chk("stallIF", stallIF, e_stall);
         chk("stallID", stallID, e_stall);
         chk("bubbleEX", bubbleEX, e_bub);
         chk("flushID", flushID, fl);
         chk("fwdA", fwdA, mfa);
         chk("fwdB", fwdB, mfb);
         chk("stallCnt", stallCnt, mcnt);
         if (reset) model_clear();
         else begin
            if (e_stall && mcnt < (1 << CW) - 1) mcnt++;
            mfa = adv ? fwd_src(ma) : 2'b00;
            mfb = adv ? fwd_src(mb) : 2'b00;
            for (int d = 3; d > 1; d--) begin
               mv[d] = mv[d-1]; mrw[d] = mrw[d-1]; mmr[d] = mmr[d-1]; mrd[d] = mrd[d-1];
            end
            mv[1] = adv; mrw[1] = regWrite; mmr[1] = memRead; mrd[1] = rd;
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
